// File: rtl/regf_pkg.sv
// Shared widths, constants and payload types for the register-file writeback arbiter.
package regf_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 1 << AW;

  localparam logic [AW-1:0] X0 = AW'(0);

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  // One register write: destination index plus data.
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regf_wb_arbiter_if.sv
// Writeback requesters, issue-stage scoreboard access and register-file write port.
interface regf_wb_arbiter_if;
  import regf_pkg::*;

  logic            a_valid;
  logic            a_ready;
  logic [AW-1:0]   a_rd;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   b_rd;
  logic [XLEN-1:0] b_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            wr_en;
  logic [AW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_data;
  logic [NREG-1:0] pending;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, issue_valid, issue_rd,
    input  a_ready, b_ready, wr_en, wr_rd, wr_data, pending
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, issue_valid, issue_rd,
    output a_ready, b_ready, wr_en, wr_rd, wr_data, pending
  );

endinterface

// File: rtl/regf_scoreboard.sv
// Per-register pending-write bits; a set and clear of the same index in one cycle leaves it set.
module regf_scoreboard
  import regf_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:0] pending_nxt_c;

  // Clear first so a same-index set overrides it; x0 never pends.
  always_comb begin
    pending_nxt_c = pending;
    if (clr_en) pending_nxt_c[clr_idx] = 1'b0;
    if (set_en) pending_nxt_c[set_idx] = 1'b1;
    pending_nxt_c[X0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt_c;
  end

endmodule

// File: rtl/regf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B) writeback.
module regf_wb_arbiter
  import regf_pkg::*;
(
  input logic              clk,
  input logic              reset,
  regf_wb_arbiter_if.slave bus
);

  grant_e          last_grant;
  logic            grant_a_c;
  logic            grant_b_c;
  logic            hs_c;
  wb_req_t         win_c;
  logic            wr_en_q;
  wb_req_t         wr_q;
  logic            set_en_c;
  logic [NREG-1:0] pending;

  // Grant includes valid, so a grant is a handshake; ties go to whoever did not win last.
  always_comb begin
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    if (!reset) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a_c = (last_grant == GNT_B);
        grant_b_c = (last_grant == GNT_A);
      end else begin
        grant_a_c = bus.a_valid;
        grant_b_c = bus.b_valid;
      end
    end
  end

  assign hs_c = grant_a_c | grant_b_c;

  always_comb begin
    win_c.rd   = grant_b_c ? bus.b_rd   : bus.a_rd;
    win_c.data = grant_b_c ? bus.b_data : bus.a_data;
  end

  // Single output register; idle cycles keep index/data and drop the enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_q       <= '0;
      last_grant <= GNT_B;
    end else begin
      wr_en_q <= hs_c && (win_c.rd != X0);
      if (hs_c) begin
        wr_q       <= win_c;
        last_grant <= grant_b_c ? GNT_B : GNT_A;
      end
    end
  end

  assign set_en_c = bus.issue_valid && (bus.issue_rd != X0);

  regf_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (set_en_c),
    .set_idx (bus.issue_rd),
    .clr_en  (wr_en_q),
    .clr_idx (wr_q.rd),
    .pending (pending)
  );

  assign bus.a_ready = grant_a_c;
  assign bus.b_ready = grant_b_c;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_rd   = wr_q.rd;
  assign bus.wr_data = wr_q.data;
  assign bus.pending = pending;

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_regf_wb_arbiter;
  import regf_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  regf_wb_arbiter_if bus ();

  regf_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who won the last handshake, what write is on the port, which registers await a write.
  bit              m_ok = 1'b0;
  bit              m_last_was_b;
  bit              m_wr_en;
  logic [AW-1:0]   m_wr_rd;
  logic [XLEN-1:0] m_wr_data;
  bit              m_pend [NREG];
  bit              e_a;
  bit              e_b;
  logic [NREG-1:0] e_pend;

  always @(negedge clk) begin
    e_a = 1'b0;
    e_b = 1'b0;
    if (!reset && m_ok) begin
      if (bus.a_valid && bus.b_valid) begin
        e_a = m_last_was_b;
        e_b = !m_last_was_b;
      end else begin
        e_a = bus.a_valid;
        e_b = bus.b_valid;
      end
    end
    chk("a_ready", bus.a_ready, 64'(e_a));
    chk("b_ready", bus.b_ready, 64'(e_b));
    if (m_ok) begin
      for (int i = 0; i < NREG; i++) e_pend[i] = m_pend[i];
      chk("wr_en", bus.wr_en, 64'(m_wr_en));
      chk("wr_rd", bus.wr_rd, 64'(m_wr_rd));
      chk("wr_data", bus.wr_data, 64'(m_wr_data));
      chk("pending", bus.pending, 64'(e_pend));
    end
    if (reset) begin
      m_ok         = 1'b1;
      m_last_was_b = 1'b1;
      m_wr_en      = 1'b0;
      m_wr_rd      = '0;
      m_wr_data    = '0;
      for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    end else if (m_ok) begin
      if (m_wr_en) m_pend[m_wr_rd] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1'b1;
      m_wr_en = 1'b0;
      if (e_a || e_b) begin
        m_last_was_b = e_b;
        m_wr_rd      = e_b ? bus.b_rd : bus.a_rd;
        m_wr_data    = e_b ? bus.b_data : bus.a_data;
        m_wr_en      = (m_wr_rd != 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_rd();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  bit a_acc;
  bit b_acc;

  initial begin
    reset = 1'b1;
    bus.a_valid = 0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_rd = '0; bus.b_data = '0;
    bus.issue_valid = 0; bus.issue_rd = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_wr_en", bus.wr_en, 64'd0);
    chk("rst_wr_rd", bus.wr_rd, 64'd0);
    chk("rst_pending", bus.pending, 64'd0);

    // Single A write, latency one cycle.
    bus.a_valid = 1; bus.a_rd = 5'd5; bus.a_data = 32'hDEADBEEF;
    #1 chk("single_a_ready", bus.a_ready, 64'd1);
    tick();
    bus.a_valid = 0;
    chk("single_wr_en", bus.wr_en, 64'd1);
    chk("single_wr_rd", bus.wr_rd, 64'd5);
    chk("single_wr_data", bus.wr_data, 64'hDEADBEEF);
    tick();
    chk("single_wr_en_off", bus.wr_en, 64'd0);

    // Tie fairness from reset: A,B,A,B with no bubble.
    reset = 1; tick(); reset = 0;
    bus.a_valid = 1; bus.a_rd = 5'd1; bus.a_data = 32'hAAAA0001;
    bus.b_valid = 1; bus.b_rd = 5'd2; bus.b_data = 32'hBBBB0002;
    for (int k = 0; k < 4; k++) begin
      #1 chk("tie_a_ready", bus.a_ready, 64'((k % 2) == 0));
      tick();
      chk("tie_wr_en", bus.wr_en, 64'd1);
      chk("tie_wr_rd", bus.wr_rd, 64'((k % 2) == 0 ? 1 : 2));
    end
    bus.a_valid = 0; bus.b_valid = 0;
    tick();

    // x0 suppression.
    bus.b_valid = 1; bus.b_rd = 5'd0; bus.b_data = 32'h1234;
    #1 chk("x0_b_ready", bus.b_ready, 64'd1);
    tick();
    bus.b_valid = 0;
    chk("x0_wr_en", bus.wr_en, 64'd0);
    chk("x0_pending", bus.pending, 64'd0);

    // Scoreboard set/clear, then same-cycle set and clear of the same index.
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_valid = 0;
    chk("sb_set", bus.pending, 64'h80);
    bus.a_valid = 1; bus.a_rd = 5'd7; bus.a_data = 32'h77;
    tick();
    bus.a_valid = 0;
    chk("sb_commit_wr_en", bus.wr_en, 64'd1);
    chk("sb_still_set", bus.pending, 64'h80);
    tick();
    chk("sb_cleared", bus.pending, 64'h0);
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_valid = 0;
    bus.a_valid = 1; bus.a_rd = 5'd7; bus.a_data = 32'h78;
    tick();
    bus.a_valid = 0;
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_valid = 0;
    chk("sb_set_wins", bus.pending, 64'h80);

    // Reset mid-operation.
    bus.issue_valid = 1; bus.issue_rd = 5'd9;
    tick();
    bus.issue_valid = 0;
    bus.a_valid = 1; bus.a_rd = 5'd9; bus.a_data = 32'h99;
    tick();
    bus.a_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_wr_en", bus.wr_en, 64'd0);
    chk("mid_rst_pending", bus.pending, 64'd0);
    bus.a_valid = 1; bus.a_rd = 5'd4; bus.b_valid = 1; bus.b_rd = 5'd6;
    #1 chk("mid_rst_tie_a", bus.a_ready, 64'd1);
    tick();
    bus.a_valid = 0; bus.b_valid = 0;

    // Idle hold after a B write to x3, then a tie goes to A.
    bus.b_valid = 1; bus.b_rd = 5'd3; bus.b_data = 32'h33;
    tick();
    bus.b_valid = 0;
    chk("idle_wr_en", bus.wr_en, 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_wr_en_off", bus.wr_en, 64'd0);
      chk("idle_wr_rd_hold", bus.wr_rd, 64'd3);
    end
    bus.a_valid = 1; bus.b_valid = 1;
    #1 chk("idle_tie_a", bus.a_ready, 64'd1);
    tick();
    bus.a_valid = 0; bus.b_valid = 0;
    tick();

    // Randomized traffic obeying the hold-until-ready rule.
    a_acc = 0;
    b_acc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (bus.a_valid && !a_acc) begin
        if ($urandom_range(0, 9) == 0) bus.a_valid = 0;
      end else begin
        bus.a_valid = 1'($urandom_range(0, 1));
        bus.a_rd    = rnd_rd();
        bus.a_data  = $urandom;
      end
      if (bus.b_valid && !b_acc) begin
        if ($urandom_range(0, 9) == 0) bus.b_valid = 0;
      end else begin
        bus.b_valid = 1'($urandom_range(0, 1));
        bus.b_rd    = rnd_rd();
        bus.b_data  = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 2) != 0);
      bus.issue_rd    = rnd_rd();
      #1;
      a_acc = bus.a_valid && bus.a_ready;
      b_acc = bus.b_valid && bus.b_ready;
      tick();
    end
    reset = 0;
    bus.a_valid = 0; bus.b_valid = 0; bus.issue_valid = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regf_wb_arbiter.md
Name: regf_wb_arbiter

Overview:
- Shares the register file's single write port (enable, destination index, write data) between two writeback requesters: A = ALU result, B = load result.
- Fair round-robin valid/ready arbitration; the winner is registered onto the write port one cycle later.
- Writes to x0 are suppressed.
- Keeps a per-register pending scoreboard (set at issue, cleared at commit) that the issue stage uses to stall on read-after-write hazards.

Parameters:
- XLEN, 32, data width of a register write.
- AW, 5, register index width; register count is 2**AW.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- a_valid  input  1  ALU writeback request.
- a_ready  output  1  ALU request accepted this cycle.
- a_rd  input  AW  ALU destination index.
- a_data  input  XLEN  ALU result.
- b_valid  input  1  load writeback request.
- b_ready  output  1  load request accepted this cycle.
- b_rd  input  AW  load destination index.
- b_data  input  XLEN  load result.
- issue_valid  input  1  an instruction with a destination is issuing.
- issue_rd  input  AW  destination of the issuing instruction.
- wr_en  output  1  drives the register file write enable.
- wr_rd  output  AW  drives the register file destination index.
- wr_data  output  XLEN  drives the register file write data.
- pending  output  2**AW  bit i = register i has an outstanding write.

Behaviour:
- Reset (synchronous, high): wr_en=0, wr_rd=0, wr_data=0, pending=all 0, last_grant=B (so A wins the first tie).
  - An accepted-but-not-yet-committed write is discarded.
  - a_ready=b_ready=0 while reset is high.
- Arbitration (combinational, same cycle):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not in last_grant.
  - Neither valid: no grant.
  - x_ready = x_valid & grant_x; at most one ready per cycle.
  - Requesters hold valid/rd/data stable until ready; a dropped valid without ready is legal (no transaction).
- last_grant updates only on a handshake (valid & ready); idle cycles keep it.
- Write port: handshake in cycle N gives, in cycle N+1:
  - wr_en=1, wr_rd/wr_data = winner's rd/data. Latency is exactly 1 cycle.
  - Register file commits at the end of N+1.
  - If the winner's rd == 0: the handshake still completes and ready is still 1, but wr_en=0 in N+1 (x0 suppressed).
  - With no handshake in N: wr_en=0 in N+1; wr_rd/wr_data hold their previous values.
- Throughput: one write per cycle, back-to-back. No internal buffering beyond the single output register.
- Scoreboard, evaluated at each rising edge in priority order:
  - reset clears all bits;
  - else issue_valid & issue_rd!=0 sets pending[issue_rd];
  - else wr_en clears pending[wr_rd].
  - Simultaneous set and clear of the same index: set wins (new producer supersedes).
  - Set and clear on different indices both take effect.
- pending[0] is constant 0.
- pending is a registered output: an issue in cycle N is visible in N+1; a commit in cycle N (wr_en=1) clears the bit as seen in N+1, the same cycle the new register value is readable.
- Writes to a non-pending register are allowed and do not corrupt other bits; issue on an already-pending register keeps it set.
- A starvation bound is inherent: with both requesters continuously valid, grants alternate A,B,A,B.

Decomposition:
- Shared package regf_pkg:
  - XLEN, AW, NREG=2**AW;
  - X0 index constant;
  - grant encoding (GNT_A=0, GNT_B=1).
- One natural sub-module: regf_scoreboard, holding the pending vector with set/clear ports and set-wins priority.
- Arbitration and output register stay in the top module.

Test Plan:
- Reset then single A: a_valid=1, a_rd=5, a_data=0xDEADBEEF in cycle 1 -> a_ready=1 in cycle 1; cycle 2 wr_en=1, wr_rd=5, wr_data=0xDEADBEEF; cycle 3 wr_en=0.
- Tie fairness: a_valid=b_valid=1 held for 4 cycles (a_rd=1, b_rd=2) -> grants A,B,A,B; wr_rd sequence 1,2,1,2 with no bubble.
- x0 suppression: b_valid=1, b_rd=0, b_data=0x1234 -> b_ready=1, next cycle wr_en=0; pending unchanged.
- Scoreboard: issue_rd=7 in cycle 1 -> pending[7]=1 from cycle 2; A writes rd=7 -> pending[7]=0 the cycle after wr_en=1. Repeat with issue_rd=7 in the same cycle as the wr_en of rd=7 -> pending[7] stays 1.
- Reset mid-operation: A handshake (rd=9) in cycle N with issue_rd=9 pending, reset=1 in cycle N+1 -> wr_en=0 in N+2, pending=0, a tie in N+2 grants A.
- Idle hold: a handshake to rd=3 followed by 3 idle cycles -> wr_en=0 on all idle cycles and wr_rd stays 3; the next tie grants the requester opposite to the last grant.
